// File: rtl/axis_pkt_stat_if.sv
// AXI-Stream beat bundle used on both sides of axis_pkt_stat.
// master drives the beat, slave returns tready.
interface axis_pkt_stat_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_stat.sv
// 2-entry skid-buffered AXIS pass-through with per-packet byte length
// strobe and clearable packet/byte totals.
module axis_pkt_stat #(
  parameter int DATA_WIDTH  = 512,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int MAX_PKT_LEN = 9216
) (
  input  logic                 aclk,
  input  logic                 areset,
  axis_pkt_stat_if.slave       s_axis,
  axis_pkt_stat_if.master      m_axis,
  input  logic                 clear_stats,
  output logic                 stat_valid,
  output logic [LEN_WIDTH-1:0] stat_len,
  output logic                 stat_oversize,
  output logic [CNT_WIDTH-1:0] stat_pkt_count,
  output logic [CNT_WIDTH-1:0] stat_byte_count
);
  localparam int BB_W  = $clog2(KEEP_WIDTH + 1);
  localparam int SUM_W = LEN_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  beat_t in_beat, out_q, skid_q;
  logic  out_vld, skid_vld, rdy_q;
  logic  accept, load_out;

  assign in_beat = '{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast};

  // rdy_q is a flop; the reset gate only keeps tready low while reset is held.
  assign s_axis.tready = rdy_q & ~areset;
  assign accept        = s_axis.tvalid & s_axis.tready;
  assign load_out      = ~out_vld | m_axis.tready;

  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_q.data;
  assign m_axis.tkeep  = out_q.keep;
  assign m_axis.tlast  = out_q.last;

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (load_out) begin
      out_vld  <= skid_vld | accept;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (accept) begin
      skid_vld <= 1'b1;
      rdy_q    <= 1'b0;
    end
  end

  // Skid is only ever filled while empty, so accept and skid_vld never coincide.
  always_ff @(posedge aclk) begin
    if (load_out && (skid_vld || accept))
      out_q <= skid_vld ? skid_q : in_beat;
    if (!load_out && accept)
      skid_q <= in_beat;
  end

  function automatic logic [BB_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [BB_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n = n + BB_W'(k[i]);
    return n;
  endfunction

  logic [LEN_WIDTH-1:0] acc, total;
  logic [SUM_W-1:0]     sum;
  logic                 done, over;

  always_comb begin
    sum   = {1'b0, acc} + SUM_W'(popcount(s_axis.tkeep));
    total = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    done  = accept & s_axis.tlast;
    over  = 64'(total) > 64'(MAX_PKT_LEN);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      acc             <= '0;
      stat_valid      <= 1'b0;
      stat_len        <= '0;
      stat_oversize   <= 1'b0;
      stat_pkt_count  <= '0;
      stat_byte_count <= '0;
    end else begin
      stat_valid <= done;
      if (accept) begin
        if (s_axis.tlast) begin
          acc           <= '0;
          stat_len      <= total;
          stat_oversize <= over;
        end else begin
          acc <= total;
        end
      end
      // Clear wins over the old totals but still counts a packet finishing now.
      if (clear_stats) begin
        stat_pkt_count  <= done ? CNT_WIDTH'(1) : '0;
        stat_byte_count <= done ? CNT_WIDTH'(total) : '0;
      end else if (done) begin
        stat_pkt_count  <= stat_pkt_count + CNT_WIDTH'(1);
        stat_byte_count <= stat_byte_count + CNT_WIDTH'(total);
      end
    end
  end
endmodule
